quadrilatero_acc_drain_stage: RTL and testbench

- Drain end of the systolic mesh: opposite direction to the weight-load stage.
- Snapshots the MESH_WIDTH x MESH_WIDTH accumulator array from the mesh into one of two ping-pong banks.
- Streams the snapshot out one packed row per handshake to the register-file writeback port.
- Double buffering lets the mesh start the next tile while the previous result is still draining.

---
 rtl/quadrilatero_acc_drain_stage.sv | 116 +++++++++++
 tb/tb_quadrilatero_acc_drain_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrilatero_acc_drain_stage.sv
// Accumulator drain stage: snapshots the mesh accumulators into ping-pong banks
// and streams each tile out one packed row (or column) per writeback handshake.
module quadrilatero_acc_drain_stage #(
    parameter int unsigned MESH_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 3
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       clear_i,
    input  logic                                       capture_i,
    output logic                                       capture_ready_o,
    input  logic                                       capture_transpose_i,
    input  logic [TAG_WIDTH-1:0]                       capture_tag_i,
    input  logic [MESH_WIDTH*MESH_WIDTH*DATA_WIDTH-1:0] acc_data_i,
    output logic                                       wb_valid_o,
    input  logic                                       wb_ready_i,
    output logic [MESH_WIDTH*DATA_WIDTH-1:0]           wb_data_o,
    output logic [$clog2(MESH_WIDTH)-1:0]              wb_row_o,
    output logic [TAG_WIDTH-1:0]                       wb_tag_o,
    output logic                                       wb_last_o,
    output logic                                       busy_o
);

    localparam int unsigned     RowW    = $clog2(MESH_WIDTH);
    localparam int unsigned     AccW    = MESH_WIDTH * MESH_WIDTH * DATA_WIDTH;
    localparam logic [RowW-1:0] LastRow = RowW'(MESH_WIDTH - 1);

    if (MESH_WIDTH < 2) begin : gen_bad_mesh_width
        $error("quadrilatero_acc_drain_stage: MESH_WIDTH must be >= 2");
    end

    logic [1:0][AccW-1:0]      bank_q;
    logic [1:0][TAG_WIDTH-1:0] tag_q;
    logic [1:0]                transpose_q;
    logic                      wr_bank_q;
    logic                      rd_bank_q;
    logic [1:0]                cnt_q;
    logic [RowW-1:0]           row_q;

    logic capture_fire;
    logic beat;
    logic last_beat;

    // Capacity is judged on cnt_q only; a same-cycle release does not free a bank.
    assign capture_ready_o = (cnt_q < 2'd2);
    assign wb_valid_o      = (cnt_q != 2'd0);
    assign busy_o          = wb_valid_o;
    assign wb_row_o        = row_q;
    assign wb_last_o       = wb_valid_o & (row_q == LastRow);
    assign wb_tag_o        = tag_q[rd_bank_q];

    assign capture_fire = capture_i & capture_ready_o;
    assign beat         = wb_valid_o & wb_ready_i;
    assign last_beat    = beat & (row_q == LastRow);

    logic [AccW-1:0] rd_data;
    logic            rd_transpose;

    assign rd_data      = bank_q[rd_bank_q];
    assign rd_transpose = transpose_q[rd_bank_q];

    for (genvar jj = 0; jj < MESH_WIDTH; jj++) begin : gen_col
        logic [31:0] row_major_idx;
        logic [31:0] col_major_idx;

        assign row_major_idx = 32'(row_q) * MESH_WIDTH + 32'(jj);
        assign col_major_idx = 32'(jj) * MESH_WIDTH + 32'(row_q);
        assign wb_data_o[DATA_WIDTH*jj +: DATA_WIDTH] = rd_transpose
            ? rd_data[DATA_WIDTH*col_major_idx +: DATA_WIDTH]
            : rd_data[DATA_WIDTH*row_major_idx +: DATA_WIDTH];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_q      <= '0;
            tag_q       <= '0;
            transpose_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            cnt_q       <= 2'd0;
            row_q       <= '0;
        end else if (clear_i) begin
            bank_q      <= '0;
            tag_q       <= '0;
            transpose_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            cnt_q       <= 2'd0;
            row_q       <= '0;
        end else begin
            // With cnt_q == 1 the write bank is never the read bank, so a capture
            // cannot clobber the tile being drained.
            if (capture_fire) begin
                bank_q[wr_bank_q]      <= acc_data_i;
                tag_q[wr_bank_q]       <= capture_tag_i;
                transpose_q[wr_bank_q] <= capture_transpose_i;
                wr_bank_q              <= ~wr_bank_q;
            end
            if (beat) begin
                if (row_q == LastRow) begin
                    row_q     <= '0;
                    rd_bank_q <= ~rd_bank_q;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end
            unique case ({capture_fire, last_beat})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_quadrilatero_acc_drain_stage.sv
// Directed bench for the accumulator drain stage (MESH_WIDTH=4, DATA_WIDTH=32).
module tb_quadrilatero_acc_drain_stage;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              clear_i;
    logic              capture_i;
    logic              capture_ready_o;
    logic              capture_transpose_i;
    logic [TW-1:0]     capture_tag_i;
    logic [N*N*DW-1:0] acc_data_i;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [N*DW-1:0]   wb_data_o;
    logic [1:0]        wb_row_o;
    logic [TW-1:0]     wb_tag_o;
    logic              wb_last_o;
    logic              busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    quadrilatero_acc_drain_stage #(
        .MESH_WIDTH(N),
        .DATA_WIDTH(DW),
        .TAG_WIDTH (TW)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .clear_i            (clear_i),
        .capture_i          (capture_i),
        .capture_ready_o    (capture_ready_o),
        .capture_transpose_i(capture_transpose_i),
        .capture_tag_i      (capture_tag_i),
        .acc_data_i         (acc_data_i),
        .wb_valid_o         (wb_valid_o),
        .wb_ready_i         (wb_ready_i),
        .wb_data_o          (wb_data_o),
        .wb_row_o           (wb_row_o),
        .wb_tag_o           (wb_tag_o),
        .wb_last_o          (wb_last_o),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [N*N*DW-1:0] mk_tile(input int base);
        logic [N*N*DW-1:0] t;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                t[DW*(r*N+c) +: DW] = DW'(base + 16*r + c);
        return t;
    endfunction

    function automatic logic [N*DW-1:0] exp_row(input int base, input int r, input bit tr);
        logic [N*DW-1:0] v;
        for (int jj = 0; jj < N; jj++)
            v[DW*jj +: DW] = tr ? DW'(base + 16*jj + r) : DW'(base + 16*r + jj);
        return v;
    endfunction

    task automatic check_row(input string tag, input int base, input int r, input bit tr,
                             input int t);
        check({tag, ".valid"}, 128'(wb_valid_o), 128'(1));
        check({tag, ".row"},   128'(wb_row_o),   128'(r));
        check({tag, ".data"},  128'(wb_data_o),  128'(exp_row(base, r, tr)));
        check({tag, ".tag"},   128'(wb_tag_o),   128'(t));
        check({tag, ".last"},  128'(wb_last_o),  128'(r == N-1));
    endtask

    // Requires wb_ready_i=1; consumes one whole tile, one beat per cycle.
    task automatic drain_tile(input string tag, input int base, input bit tr, input int t);
        for (int r = 0; r < N; r++) begin
            check_row($sformatf("%s.r%0d", tag, r), base, r, tr, t);
            tick();
        end
    endtask

    task automatic do_capture(input int base, input bit tr, input int t);
        acc_data_i          = mk_tile(base);
        capture_transpose_i = tr;
        capture_tag_i       = TW'(t);
        capture_i           = 1'b1;
        tick();
        capture_i = 1'b0;
    endtask

    int beats;
    int exp_r;
    bit stalled;

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; capture_i = 1'b0; capture_transpose_i = 1'b0;
        capture_tag_i = '0; acc_data_i = '0; wb_ready_i = 1'b0;
        #12;
        check("rst.cap_ready", 128'(capture_ready_o), 128'(1));
        check("rst.valid",     128'(wb_valid_o),      128'(0));
        check("rst.data",      128'(wb_data_o),       128'(0));
        check("rst.row",       128'(wb_row_o),        128'(0));
        check("rst.tag",       128'(wb_tag_o),        128'(0));
        check("rst.last",      128'(wb_last_o),       128'(0));
        check("rst.busy",      128'(busy_o),          128'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // Single tile, streaming at full rate.
        wb_ready_i = 1'b1;
        do_capture(0, 1'b0, 5);
        check("single.row1_lit_pre", 128'(wb_busy_or_valid()), 128'(1));
        check_row("single.r0", 0, 0, 1'b0, 5);
        tick();
        check("single.row1_lit", 128'(wb_data_o),
              128'({32'h13, 32'h12, 32'h11, 32'h10}));
        tick();
        check_row("single.r2", 0, 2, 1'b0, 5);
        tick();
        check_row("single.r3", 0, 3, 1'b0, 5);
        tick();
        check("single.busy_end",  128'(busy_o),     128'(0));
        check("single.valid_end", 128'(wb_valid_o), 128'(0));

        // Transposed tile.
        do_capture(0, 1'b1, 2);
        check("tr.first_lit", 128'(wb_data_o), 128'({32'h30, 32'h20, 32'h10, 32'h00}));
        tick(); tick(); tick();
        check("tr.last_lit",  128'(wb_data_o), 128'({32'h33, 32'h23, 32'h13, 32'h03}));
        check("tr.last_flag", 128'(wb_last_o), 128'(1));
        tick();
        check("tr.valid_end", 128'(wb_valid_o), 128'(0));

        // Backpressure: ready pattern 1,0,0,1,0,0,...
        wb_ready_i = 1'b0;
        do_capture(0, 1'b0, 3);
        beats = 0; exp_r = 0;
        for (int k = 0; k < 16; k++) begin
            wb_ready_i = (k % 3 == 0);
            stalled = 1'b0;
            if (wb_valid_o) begin
                if (wb_ready_i) begin
                    check($sformatf("bp.k%0d.row", k),  128'(wb_row_o),  128'(exp_r));
                    check($sformatf("bp.k%0d.data", k), 128'(wb_data_o),
                          128'(exp_row(0, exp_r, 1'b0)));
                    beats++;
                    exp_r++;
                end else begin
                    stalled = 1'b1;
                end
            end
            tick();
            if (stalled) begin
                check($sformatf("bp.k%0d.hold_row", k),  128'(wb_row_o),  128'(exp_r));
                check($sformatf("bp.k%0d.hold_data", k), 128'(wb_data_o),
                      128'(exp_row(0, exp_r, 1'b0)));
                check($sformatf("bp.k%0d.hold_last", k), 128'(wb_last_o), 128'(exp_r == N-1));
            end
        end
        check("bp.beats",     128'(beats),      128'(4));
        check("bp.valid_end", 128'(wb_valid_o), 128'(0));

        // Full: A and B captured under backpressure, C refused.
        wb_ready_i = 1'b0;
        do_capture('h000, 1'b0, 1);
        check("full.ready_after_a", 128'(capture_ready_o), 128'(1));
        do_capture('h100, 1'b0, 2);
        check("full.ready_after_b", 128'(capture_ready_o), 128'(0));
        acc_data_i = mk_tile('h200); capture_tag_i = 3'd7; capture_i = 1'b1;
        tick(); tick();
        capture_i = 1'b0;
        check("full.ready_c", 128'(capture_ready_o), 128'(0));
        wb_ready_i = 1'b1;
        drain_tile("full.a", 'h000, 1'b0, 1);
        drain_tile("full.b", 'h100, 1'b0, 2);
        check("full.no_c", 128'(wb_valid_o), 128'(0));

        // Capture coinciding with last beat.
        wb_ready_i = 1'b0;
        do_capture('h000, 1'b0, 1);
        do_capture('h100, 1'b0, 2);
        wb_ready_i = 1'b1;
        for (int r = 0; r < N-1; r++) begin
            check_row($sformatf("sim.a.r%0d", r), 'h000, r, 1'b0, 1);
            tick();
        end
        acc_data_i = mk_tile('h200); capture_tag_i = 3'd4; capture_i = 1'b1;
        check("sim.a.last_pre", 128'(wb_last_o), 128'(1));
        tick();
        capture_i = 1'b0;
        check("sim.cnt2_rejected", 128'(capture_ready_o), 128'(1));
        for (int r = 0; r < N-1; r++) begin
            check_row($sformatf("sim.b.r%0d", r), 'h100, r, 1'b0, 2);
            tick();
        end
        check("sim.b.last_pre", 128'(wb_last_o), 128'(1));
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
        check("sim.cnt1_accepted", 128'(capture_ready_o), 128'(1));
        drain_tile("sim.c", 'h200, 1'b0, 4);
        check("sim.valid_end", 128'(wb_valid_o), 128'(0));

        // Clear mid-drain at row 2 with the second bank full.
        wb_ready_i = 1'b0;
        do_capture('h000, 1'b0, 1);
        do_capture('h100, 1'b0, 2);
        wb_ready_i = 1'b1;
        tick(); tick();
        check("clr.row_before", 128'(wb_row_o), 128'(2));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        wb_ready_i = 1'b0;
        check("clr.valid",     128'(wb_valid_o),      128'(0));
        check("clr.cap_ready", 128'(capture_ready_o), 128'(1));
        check("clr.row",       128'(wb_row_o),        128'(0));
        check("clr.busy",      128'(busy_o),          128'(0));
        check("clr.data_zero", 128'(wb_data_o),       128'(0));
        check("clr.tag_zero",  128'(wb_tag_o),        128'(0));
        do_capture('h300, 1'b0, 6);
        wb_ready_i = 1'b1;
        drain_tile("clr.d", 'h300, 1'b0, 6);
        check("clr.valid_end", 128'(wb_valid_o), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic wb_busy_or_valid();
        return busy_o & wb_valid_o;
    endfunction

endmodule
